// File: rtl/spi_responder_if.sv
// spi_responder_if: word-level transmit/receive handshake between host logic and the SPI responder
//   tx_data/tx_valid/tx_ready : host writes the next word to transmit (accepted when valid && ready)
//   rx_data/rx_valid          : last complete received word, rx_valid pulses one cycle on update
interface spi_responder_if #(
    parameter int REG_WIDTH = 32
);
    logic [REG_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [REG_WIDTH-1:0] rx_data;
    logic                 rx_valid;
    modport master(output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
    modport slave(input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_responder.sv
// spi_responder: SPI mode 0 responder oversampling SCLK/CS_N/MOSI on the system clock
//   clk, rst_n   : system clock, asynchronous active-low reset
//   i_sclk       : SPI clock from master (idle low)
//   i_cs_n       : chip select from master (active low)
//   i_mosi       : serial data from master
//   i_lsb_first  : bit order, sampled at frame start (1 = LSB first)
//   o_miso       : registered serial data to master
//   o_busy       : frame in progress (synchronized cs_n low)
//   bus          : word handshake (tx holding register in, received word out)
module spi_responder #(
    parameter int REG_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    input  logic                  i_lsb_first,
    output logic                  o_miso,
    output logic                  o_busy,
    spi_responder_if.slave        bus
);
    localparam int CW = $clog2(REG_WIDTH + 1);
    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d, r_armed;
    logic                   w_sclk, w_cs, w_mosi, w_rise, w_fall, w_fs, w_fe;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [REG_WIDTH-1:0]   r_rx_sh, w_rx_sh_nxt, r_tx_sh, w_tx_sh_nxt;
    logic [REG_WIDTH-1:0]   r_rx_data, w_rx_data_nxt, r_tx_hold;
    logic                   r_order, w_order_nxt, r_skip, w_skip_nxt;
    logic                   r_rx_valid, w_rx_valid_nxt, r_miso, w_miso_nxt;
    logic                   r_tx_full, w_load;

    // cs_n flops reset low so a cs_n held low across reset never looks like a
    // falling edge; r_armed records that cs_n has truly been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_armed     <= r_armed | r_cs_d;
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;
    assign w_fall = ~w_sclk & r_sclk_d;
    assign w_fs   = r_cs_d & ~w_cs;
    assign w_fe   = ~r_cs_d & w_cs;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rx_sh_nxt    = r_rx_sh;
        w_tx_sh_nxt    = r_tx_sh;
        w_order_nxt    = r_order;
        w_skip_nxt     = r_skip;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_load         = 1'b0;
        if (w_fe) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_skip_nxt  = 1'b0;
        end else if (r_state == IDLE) begin
            w_cnt_nxt = '0;
            if (w_fs) begin
                w_order_nxt = i_lsb_first;
                w_load      = 1'b1;
                w_state_nxt = ACTIVE;
            end
        end else if (w_rise) begin
            w_rx_sh_nxt = r_order ? {w_mosi, r_rx_sh[REG_WIDTH-1:1]} : {r_rx_sh[REG_WIDTH-2:0], w_mosi};
            if (r_cnt == CW'(REG_WIDTH - 1)) begin
                w_rx_data_nxt  = w_rx_sh_nxt;
                w_rx_valid_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_load         = 1'b1;
                // the reloaded first bit must survive the fall that ends this bit
                w_skip_nxt     = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (w_fall) begin
            if (r_skip)
                w_skip_nxt = 1'b0;
            else
                w_tx_sh_nxt = r_order ? {1'b0, r_tx_sh[REG_WIDTH-1:1]} : {r_tx_sh[REG_WIDTH-2:0], 1'b0};
        end
        if (w_load)
            w_tx_sh_nxt = r_tx_full ? r_tx_hold : '0;
        w_miso_nxt = (w_state_nxt == ACTIVE) & (w_order_nxt ? w_tx_sh_nxt[0] : w_tx_sh_nxt[REG_WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_order    <= 1'b0;
            r_skip     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_order    <= w_order_nxt;
            r_skip     <= w_skip_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_miso     <= w_miso_nxt;
        end
    end

    // a load in the same cycle as a write sees the old (empty) flag, so the
    // written word stays in the holding register for the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_full <= 1'b0;
            r_tx_hold <= '0;
        end else begin
            if (w_load)
                r_tx_full <= 1'b0;
            if (bus.tx_valid && !r_tx_full) begin
                r_tx_full <= 1'b1;
                r_tx_hold <= bus.tx_data;
            end
        end
    end

    assign bus.tx_ready = ~r_tx_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign o_miso       = r_miso;
    assign o_busy       = r_armed & ~r_cs_d;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: randomized Mode 0 master driving spi_responder against a word-level model
`timescale 1ns/1ps
module tb_spi_responder;
    localparam int W = 32;
    localparam int S = 2;
    localparam int H = 8;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, lsb_first = 1'b0;
    logic miso, busy;
    spi_responder_if #(.REG_WIDTH(W)) bus();

    spi_responder #(.REG_WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .i_lsb_first(lsb_first), .o_miso(miso), .o_busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, nvalid = 0;
    logic [W-1:0] rxq[$];
    logic prev_v = 1'b0;
    logic [W-1:0] mo[4], got[4], ex[4], rf_val[4];
    bit rf_en[4];
    bit m_full = 1'b0;
    logic [W-1:0] m_hold = '0, m_rx = '0;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            nvalid++;
            rxq.push_back(bus.rx_data);
            checks++;
            if (prev_v === 1'b1) begin
                errors++;
                $display("FAIL rx_valid_width: high %0d cycles running, required 1", 2);
            end
        end
        prev_v <= bus.rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [W-1:0] v);
        int t = 0;
        while (bus.tx_ready !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_wait: tx_ready=%b, required 1", bus.tx_ready);
        end
        bus.tx_valid = 1'b1;
        bus.tx_data = v;
        tick(1);
        bus.tx_valid = 1'b0;
        m_hold = v;
        m_full = 1'b1;
    endtask

    task automatic xfer_word(input logic [W-1:0] m, input bit lsb, input int nbits, output logic [W-1:0] r);
        int b;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            b = lsb ? i : W - 1 - i;
            mosi = m[b];
            tick(H);
            r[b] = miso;
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    // model: each word start (frame start or completion) takes the holding word if present, else zeros
    task automatic run_frame(input int nw, input bit lsb, input int lastbits, input bit co, input logic [W-1:0] cov);
        rxq.delete();
        lsb_first = lsb;
        cs_n = 1'b0;
        ex[0] = m_full ? m_hold : '0;
        m_full = 1'b0;
        if (co) begin
            tick(S);
            bus.tx_valid = 1'b1;
            bus.tx_data = cov;
            tick(1);
            bus.tx_valid = 1'b0;
            m_hold = cov;
            m_full = 1'b1;
            tick(H - S - 1);
        end else begin
            tick(H);
        end
        lsb_first = 1'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame: busy=%b, required 1", busy);
        end
        for (int k = 0; k < nw; k++) begin
            if (rf_en[k]) tx_write(rf_val[k]);
            xfer_word(mo[k], lsb, (k == nw - 1) ? lastbits : W, got[k]);
            if (k < nw - 1 || lastbits == W) begin
                m_rx = mo[k];
                ex[k + 1] = m_full ? m_hold : '0;
                m_full = 1'b0;
            end
        end
        tick(H);
        cs_n = 1'b1;
        tick(3 * H);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 4; k++) begin
            rf_en[k] = 1'b0;
            rf_val[k] = $urandom;
            mo[k] = $urandom;
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] tmp;
        int n0;
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({miso, bus.tx_ready, bus.rx_valid, busy, bus.rx_data} !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_values: miso=%b ready=%b valid=%b busy=%b rx=%h, required 0 1 0 0 0",
                     miso, bus.tx_ready, bus.rx_valid, busy, bus.rx_data);
        end
        rst_n = 1'b1;
        tick(4 * H);
        cs_n = 1'b0;
        tick(H);
        tx_write($urandom);
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_ready_after_write: tx_ready=%b, required 0", bus.tx_ready);
        end
        xfer_word($urandom, 1'b0, 10, tmp);
        sclk = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({miso, bus.tx_ready, bus.rx_valid, busy, bus.rx_data} !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL midframe_reset: miso=%b ready=%b valid=%b busy=%b rx=%h, required 0 1 0 0 0",
                     miso, bus.tx_ready, bus.rx_valid, busy, bus.rx_data);
        end
        m_full = 1'b0;
        m_rx = '0;
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4 * H);
        clear_plan();
        tx_write($urandom);
        n0 = nvalid;
        run_frame(1, 1'b0, W, 1'b0, '0);
        checks++;
        if (got[0] !== ex[0] || bus.rx_data !== mo[0] || nvalid - n0 != 1) begin
            errors++;
            $display("FAIL post_reset_frame: miso_word=%h rx=%h pulses=%0d, required %h %h 1",
                     got[0], bus.rx_data, nvalid - n0, ex[0], mo[0]);
        end
    endtask

    task automatic test_single(input bit lsb);
        int n0;
        clear_plan();
        tx_write(32'hA5A5_0F0F);
        mo[0] = 32'h1234_5678;
        n0 = nvalid;
        run_frame(1, lsb, W, 1'b0, '0);
        checks++;
        if (got[0] !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL miso_word lsb=%0d: got %h, required %h", lsb, got[0], 32'hA5A5_0F0F);
        end
        checks++;
        if (bus.rx_data !== 32'h1234_5678 || nvalid - n0 != 1) begin
            errors++;
            $display("FAIL rx_word lsb=%0d: rx=%h pulses=%0d, required %h 1", lsb, bus.rx_data, nvalid - n0, 32'h1234_5678);
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_after_load: tx_ready=%b, required 1", bus.tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        clear_plan();
        tx_write($urandom);
        rf_en[0] = 1'b1;
        n0 = nvalid;
        run_frame(3, 1'($urandom), W, 1'b0, '0);
        checks++;
        if (ex[1] !== rf_val[0] || ex[2] !== '0) begin
            errors++;
            $display("FAIL b2b_model: word1=%h word2=%h, required %h 0", ex[1], ex[2], rf_val[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== ex[k] || rxq.size() <= k || rxq[k] !== mo[k]) begin
                errors++;
                $display("FAIL b2b_word%0d: miso=%h rx=%h, required %h %h", k, got[k],
                         (rxq.size() > k) ? rxq[k] : 'x, ex[k], mo[k]);
            end
        end
        checks++;
        if (nvalid - n0 != 3) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, required 3", nvalid - n0);
        end
    endtask

    task automatic test_abort();
        int n0;
        logic [W-1:0] old;
        clear_plan();
        tx_write($urandom);
        old = m_rx;
        n0 = nvalid;
        run_frame(1, 1'b0, 13, 1'b0, '0);
        checks++;
        if (nvalid != n0 || bus.rx_data !== old || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: pulses=%0d rx=%h busy=%b, required 0 %h 0", nvalid - n0, bus.rx_data, busy, old);
        end
        clear_plan();
        tx_write($urandom);
        n0 = nvalid;
        run_frame(1, 1'b1, W, 1'b0, '0);
        checks++;
        if (got[0] !== ex[0] || bus.rx_data !== mo[0] || nvalid - n0 != 1) begin
            errors++;
            $display("FAIL after_abort: miso=%h rx=%h pulses=%0d, required %h %h 1",
                     got[0], bus.rx_data, nvalid - n0, ex[0], mo[0]);
        end
    endtask

    task automatic test_coincide();
        logic [W-1:0] v;
        clear_plan();
        v = $urandom | 32'h1;
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL coincide_precondition: tx_ready=%b, required 1", bus.tx_ready);
        end
        run_frame(2, 1'b0, W, 1'b1, v);
        checks++;
        if (got[0] !== '0 || got[1] !== v) begin
            errors++;
            $display("FAIL coincide: words %h %h, required 0 %h", got[0], got[1], v);
        end
    endtask

    task automatic test_random();
        int nw, lb, n0, nc;
        bit co;
        for (int f = 0; f < 6; f++) begin
            clear_plan();
            nw = $urandom_range(1, 3);
            lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : W;
            co = !m_full && ($urandom_range(0, 3) == 0);
            if (!co && $urandom_range(0, 1) == 1 && !m_full) tx_write($urandom);
            for (int k = 0; k < nw; k++) rf_en[k] = (k > 0 || !co) && ($urandom_range(0, 1) == 1);
            n0 = nvalid;
            run_frame(nw, 1'($urandom), lb, co, $urandom);
            nc = (lb == W) ? nw : nw - 1;
            for (int k = 0; k < nc; k++) begin
                checks++;
                if (got[k] !== ex[k] || rxq.size() <= k || rxq[k] !== mo[k]) begin
                    errors++;
                    $display("FAIL random_f%0d_w%0d: miso=%h rx=%h, required %h %h", f, k, got[k],
                             (rxq.size() > k) ? rxq[k] : 'x, ex[k], mo[k]);
                end
            end
            checks++;
            if (nvalid - n0 != nc || bus.rx_data !== m_rx) begin
                errors++;
                $display("FAIL random_f%0d_rx: pulses=%0d rx=%h, required %0d %h", f, nvalid - n0, bus.rx_data, nc, m_rx);
            end
        end
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_back_to_back();
        test_abort();
        test_coincide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
